ones_word_packer: RTL and testbench
===================================

// Module: ones_word_packer
// PURPOSE
//  Upstream feeder for the popcount stage. Accepts a byte stream with a valid/ready handshake.
//  Packs bytes into 32-bit words and presents each word with a valid strobe on data/data_valid.
//  Partial final words of a frame are zero-padded, so popcount downstream is unaffected.
//  Reports byte count per word and per frame, so downstream can normalise the ones-count.
// PARAMETERS
//  BYTE_ORDER  0   0: first byte of word -> data[7:0] (LE); 1: first byte -> data[31:24] (BE)
//  FRAME_W     16  width of frame byte counter; saturates at 2**FRAME_W-1
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  counter_reset  in   1        reset, synchronous, active-high
//  in_data        in   8        input byte
//  in_valid       in   1        in_data/in_last valid
//  in_last        in   1        byte is last of frame
//  in_ready       out  1        block accepts byte this cycle
//  out_ready      in   1        downstream accepts word (tie 1 when driving popcount stage)
//  data           out  32       packed word, unused lanes 0
//  data_valid     out  1        data/data_last/data_bytes/frame_bytes valid
//  data_last      out  1        word is last of frame
//  data_bytes     out  3        number of real bytes in word, 1..4
//  frame_bytes    out  FRAME_W  total bytes in frame; meaningful only when data_last=1, else 0
// BEHAVIOUR
//  - Byte accepted when in_valid && in_ready. Input handshake: in_ready = !counter_reset && (!data_valid || out_ready).
//  - Word output handshake: word transferred when data_valid && out_ready.
//  - Output register holds stable while data_valid && !out_ready.
//  - Internal lane index idx (0..3) and 24-bit assembly reg hold bytes 0..2 of the current word.
//  - Word completes on an accepted byte with idx==3 or in_last=1. On that edge:
//    - output reg loads assembled word plus current byte.
//    - data_valid<=1, data_bytes<=idx+1, data_last<=in_last.
//    - idx<=0, assembly reg<=0.
//  - Accepted byte that does not complete a word: store in lane idx, idx<=idx+1.
//  - Latency: data_valid high the cycle after the completing byte is accepted.
//  - Throughput: one byte/cycle sustained with out_ready=1, one word every 4 cycles.
//  - Drain without new completion: data_valid<=0 on a transfer edge that does not also load a word.
//  - Simultaneous drain and load: the new word replaces the old one; data_valid stays 1, no bubble.
//  - Lane mapping:
//    - BYTE_ORDER=0: byte k -> data[8k+7:8k].
//    - BYTE_ORDER=1: byte k -> data[31-8k:24-8k].
//    - Lanes >= data_bytes are 0 in both orders.
//  - Frame counter fcnt: +1 per accepted byte, saturates at all-ones (no wrap).
//    - On the last byte, frame_bytes<=fcnt+1 (saturated) and fcnt<=0.
//    - On a non-last word, frame_bytes<=0.
//  - in_last on a byte with idx==3 yields a full word with data_last=1, data_bytes=4.
//  - in_last on the first byte of a frame yields a 1-byte word, frame_bytes=1.
//  - Reset (synchronous, any cycle, including mid-word or while stalled):
//    - data=0, data_valid=0, data_last=0, data_bytes=0, frame_bytes=0.
//    - idx=0, assembly reg=0, fcnt=0.
//    - Partial word discarded; in_ready=0 during the reset cycle.
//  - No state machine beyond idx plus the output-full flag: FILL (data_valid=0) / HOLD (data_valid=1).
//    - HOLD->FILL on drain without load.
//    - FILL->HOLD on completing byte.
// TESTING
//  1 LE, out_ready=1, bytes 01,02,03,04 (last on 04) -> data=0x04030201 1 cycle after 04;
//    data_bytes=4, data_last=1, frame_bytes=4.
//  2 BE, bytes FF,0F,last on 0F -> data=0xFF0F0000, data_bytes=2, data_last=1, frame_bytes=2.
//  3 LE, 9 bytes AA.. last on 9th -> two words with data_bytes=4, data_last=0, frame_bytes=0;
//    then data=0x000000AA, data_bytes=1, frame_bytes=9.
//  4 out_ready=0 after first word completes -> data held stable, in_ready=0;
//    release out_ready -> in_ready=1 same cycle, next word with no loss or duplication.
//  5 Reset after 2 bytes of a word -> all outputs 0 next cycle;
//    next frame of 4 bytes packs from lane 0, frame_bytes=4.
//  6 FRAME_W=4, 20-byte frame -> frame_bytes=15 (saturated) on final word, fcnt restarts at 0 for next frame.

Source files
------------

// File: rtl/ones_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : ones_word_packer_if
// Brief    : Byte-in / word-out stream bundle for ones_word_packer.
//            The master drives bytes and out_ready; the slave (the packer)
//            drives in_ready and the packed word outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface ones_word_packer_if #(
    parameter int FRAME_W = 16
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic               out_ready;
    logic [31:0]        data;
    logic               data_valid;
    logic               data_last;
    logic [2:0]         data_bytes;
    logic [FRAME_W-1:0] frame_bytes;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, data, data_valid, data_last, data_bytes, frame_bytes
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, data, data_valid, data_last, data_bytes, frame_bytes
    );
endinterface
`default_nettype wire

// File: rtl/ones_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : ones_word_packer
// Brief    : Packs a byte stream into zero-padded 32-bit words, reporting the
//            real byte count per word and the (saturating) byte count per
//            frame on the last word of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module ones_word_packer #(
    parameter int BYTE_ORDER = 0,
    parameter int FRAME_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             counter_reset,
    ones_word_packer_if.slave     bus
);
    // FILL: output register empty; HOLD: output register presents a word
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         idx;
    logic [23:0]        asm_word;
    logic [FRAME_W-1:0] fcnt;
    logic [FRAME_W-1:0] fcnt_inc;
    logic [31:0]        data_r;
    logic               data_last_r;
    logic [2:0]         data_bytes_r;
    logic [FRAME_W-1:0] frame_bytes_r;
    logic               in_ready;
    logic               accept;
    logic               complete;
    logic               drain;
    logic [31:0]        le_word;
    logic [31:0]        packed_word;

    assign in_ready = !counter_reset && ((state == FILL) || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && ((idx == 2'd3) || bus.in_last);
    assign drain    = (state == HOLD) && bus.out_ready;
    assign fcnt_inc = (&fcnt) ? fcnt : fcnt + 1'b1;

    assign bus.in_ready    = in_ready;
    assign bus.data        = data_r;
    assign bus.data_valid  = (state == HOLD);
    assign bus.data_last   = data_last_r;
    assign bus.data_bytes  = data_bytes_r;
    assign bus.frame_bytes = frame_bytes_r;

    // Assembled word in little-endian lane order with the incoming byte
    // dropped into lane idx; lanes above idx are still zero from the clear.
    always_comb begin
        le_word = {8'h00, asm_word};
        le_word[{idx, 3'b000} +: 8] = bus.in_data;
    end

    // Final lane mapping applied only when the word is loaded for output
    generate
        if (BYTE_ORDER == 0) begin : g_le
            assign packed_word = le_word;
        end else begin : g_be
            assign packed_word = {le_word[7:0], le_word[15:8],
                                  le_word[23:16], le_word[31:24]};
        end
    endgenerate

    // Output-full flag register
    always_ff @(posedge clk) begin
        if (counter_reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // A completing byte always (re)loads, so load takes priority over drain
    always_comb begin
        state_next = state;
        if (complete) begin
            state_next = HOLD;
        end else if (drain) begin
            state_next = FILL;
        end
    end

    // Lane assembly, frame counting and output word register
    always_ff @(posedge clk) begin
        if (counter_reset) begin
            idx           <= 2'd0;
            asm_word      <= 24'd0;
            fcnt          <= '0;
            data_r        <= 32'd0;
            data_last_r   <= 1'b0;
            data_bytes_r  <= 3'd0;
            frame_bytes_r <= '0;
        end else if (accept) begin
            fcnt <= bus.in_last ? '0 : fcnt_inc;
            if (complete) begin
                data_r        <= packed_word;
                data_bytes_r  <= {1'b0, idx} + 3'd1;
                data_last_r   <= bus.in_last;
                frame_bytes_r <= bus.in_last ? fcnt_inc : '0;
                idx           <= 2'd0;
                asm_word      <= 24'd0;
            end else begin
                asm_word <= le_word[23:0];
                idx      <= idx + 2'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ones_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ones_word_packer
// Brief    : Drives three packer configurations (LE/16, BE/16, LE/4) with the
//            same directed byte stream and checks them against a word-level
//            model of the packing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ones_word_packer;
    logic       clk;
    logic       counter_reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    int checks = 0;
    int passes = 0;

    ones_word_packer_if #(.FRAME_W(16)) bus_le ();
    ones_word_packer_if #(.FRAME_W(16)) bus_be ();
    ones_word_packer_if #(.FRAME_W(4))  bus_sat ();

    assign bus_le.in_data   = in_data;
    assign bus_le.in_valid  = in_valid;
    assign bus_le.in_last   = in_last;
    assign bus_le.out_ready = out_ready;
    assign bus_be.in_data   = in_data;
    assign bus_be.in_valid  = in_valid;
    assign bus_be.in_last   = in_last;
    assign bus_be.out_ready = out_ready;
    assign bus_sat.in_data   = in_data;
    assign bus_sat.in_valid  = in_valid;
    assign bus_sat.in_last   = in_last;
    assign bus_sat.out_ready = out_ready;

    ones_word_packer #(.BYTE_ORDER(0), .FRAME_W(16)) u_le (
        .clk(clk), .counter_reset(counter_reset), .bus(bus_le));
    ones_word_packer #(.BYTE_ORDER(1), .FRAME_W(16)) u_be (
        .clk(clk), .counter_reset(counter_reset), .bus(bus_be));
    ones_word_packer #(.BYTE_ORDER(0), .FRAME_W(4)) u_sat (
        .clk(clk), .counter_reset(counter_reset), .bus(bus_sat));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] le;
        int          n;
        bit          last;
        int          fc;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] cur_le   = '0;
    int          cur_n    = 0;
    int          fcount   = 0;
    bit          zero_exp = 1'b1;

    function automatic logic [31:0] to_be(input logic [31:0] le);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[31-8*k -: 8] = le[8*k +: 8];
        return r;
    endfunction

    function automatic int sat(input int fc, input int fw);
        int m;
        m = (1 << fw) - 1;
        return (fc > m) ? m : fc;
    endfunction

    task automatic check_dut(input string tag, input bit be, input int fw,
                             input logic dv, input logic [31:0] d, input logic dl,
                             input logic [2:0] db, input logic [15:0] fb);
        word_t w;
        if (exp_q.size() > 0) begin
            w = exp_q[0];
            chk({tag, ".data_valid"}, dv, 1);
            chk({tag, ".data"}, d, be ? to_be(w.le) : w.le);
            chk({tag, ".data_bytes"}, db, w.n);
            chk({tag, ".data_last"}, dl, w.last);
            chk({tag, ".frame_bytes"}, fb, w.last ? sat(w.fc, fw) : 0);
        end else begin
            chk({tag, ".data_valid"}, dv, 0);
            if (zero_exp) begin
                chk({tag, ".data_zero"}, d, 0);
                chk({tag, ".last_zero"}, dl, 0);
                chk({tag, ".bytes_zero"}, db, 0);
                chk({tag, ".frame_zero"}, fb, 0);
            end
        end
    endtask

    // Compare against the model, then advance it by the coming edge's inputs
    always @(negedge clk) begin
        bit exp_ready;
        check_dut("le", 1'b0, 16, bus_le.data_valid, bus_le.data, bus_le.data_last,
                  bus_le.data_bytes, bus_le.frame_bytes);
        check_dut("be", 1'b1, 16, bus_be.data_valid, bus_be.data, bus_be.data_last,
                  bus_be.data_bytes, bus_be.frame_bytes);
        check_dut("sat", 1'b0, 4, bus_sat.data_valid, bus_sat.data, bus_sat.data_last,
                  bus_sat.data_bytes, {12'd0, bus_sat.frame_bytes});
        exp_ready = !counter_reset && ((exp_q.size() == 0) || out_ready);
        chk("le.in_ready", bus_le.in_ready, exp_ready);
        chk("be.in_ready", bus_be.in_ready, exp_ready);
        chk("sat.in_ready", bus_sat.in_ready, exp_ready);
        if (counter_reset) begin
            exp_q.delete();
            cur_le   = '0;
            cur_n    = 0;
            fcount   = 0;
            zero_exp = 1'b1;
        end else begin
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_ready) begin
                cur_le[8*cur_n +: 8] = in_data;
                cur_n++;
                fcount++;
                if (cur_n == 4 || in_last) begin
                    exp_q.push_back('{le: cur_le, n: cur_n, last: in_last,
                                      fc: in_last ? fcount : 0});
                    zero_exp = 1'b0;
                    cur_le   = '0;
                    cur_n    = 0;
                    if (in_last) fcount = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = bus_le.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        counter_reset = 1'b1;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        in_data       = 8'h00;
        out_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1 counter_reset = 1'b0;

        // 1: LE full word, last on 4th byte
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 1);
        chk("t1.data", bus_le.data, 32'h04030201);
        chk("t1.bytes", bus_le.data_bytes, 4);
        chk("t1.last", bus_le.data_last, 1);
        chk("t1.frame", bus_le.frame_bytes, 4);

        // 2: two-byte frame, BE and LE views
        send_byte(8'hFF, 0); send_byte(8'h0F, 1);
        chk("t2.be_data", bus_be.data, 32'hFF0F0000);
        chk("t2.le_data", bus_le.data, 32'h00000FFF);
        chk("t2.bytes", bus_be.data_bytes, 2);
        chk("t2.frame", bus_be.frame_bytes, 2);

        // 3: nine-byte frame -> 4 + 4 + 1
        for (int i = 0; i < 9; i++) send_byte(8'hAA, (i == 8));
        chk("t3.data", bus_le.data, 32'h000000AA);
        chk("t3.bytes", bus_le.data_bytes, 1);
        chk("t3.frame", bus_le.frame_bytes, 9);

        // 4: stall after first word, then release
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), (i == 7));
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("t4.held_valid", bus_le.data_valid, 1);
                chk("t4.held_data", bus_le.data, 32'h14131211);
                chk("t4.stall_ready", bus_le.in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                #1 chk("t4.release_ready", bus_le.in_ready, 1);
            end
        join
        chk("t4.data2", bus_le.data, 32'h18171615);
        chk("t4.frame", bus_le.frame_bytes, 8);

        // 5: reset mid-word, byte offered during reset is dropped
        send_byte(8'h21, 0); send_byte(8'h22, 0);
        counter_reset = 1'b1;
        in_valid      = 1'b1;
        in_data       = 8'h99;
        @(posedge clk);
        #1;
        chk("t5.valid", bus_le.data_valid, 0);
        chk("t5.data", bus_le.data, 0);
        chk("t5.bytes", bus_le.data_bytes, 0);
        chk("t5.rst_ready", bus_le.in_ready, 0);
        counter_reset = 1'b0;
        in_valid      = 1'b0;
        send_byte(8'h31, 0); send_byte(8'h32, 0);
        send_byte(8'h33, 0); send_byte(8'h34, 1);
        chk("t5.data2", bus_le.data, 32'h34333231);
        chk("t5.frame", bus_le.frame_bytes, 4);

        // 6: 20-byte frame saturates a 4-bit counter, then restarts
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1), (i == 19));
        chk("t6.sat_frame", bus_sat.frame_bytes, 15);
        chk("t6.wide_frame", bus_le.frame_bytes, 20);
        for (int i = 0; i < 3; i++) send_byte(8'h80, (i == 2));
        chk("t6.restart", bus_sat.frame_bytes, 3);

        repeat (5) @(posedge clk);
        #1 chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
